bank_loader: RTL and testbench

BANK_LOADER -- requirements
Module: bank_loader

---
 rtl/bank_loader.sv | 157 +++++++++++++++
 tb/tb_bank_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_loader.sv
// Streams words round-robin into N_PE bank write ports, one row per N_PE words.
// Optional BANK_LOADER_DROPCNT_EN adds a saturating drop_cnt output.

`ifndef N_PE
`define N_PE 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif
`ifndef WID_RAM
`define WID_RAM 16
`endif

module bank_loader #(
  parameter int unsigned N_PE   = `N_PE,
  parameter int unsigned ADDR_W = `ADDR_RAM,
  parameter int unsigned DATA_W = `WID_RAM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mode,
  output logic [N_PE-1:0]   m0_w_en,
  output logic [ADDR_W-1:0] m0_w_addr,
  output logic [DATA_W-1:0] m0_w_data,
  output logic              busy,
  output logic              done
`ifdef BANK_LOADER_DROPCNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int unsigned BankW = $clog2(N_PE);
  localparam logic [BankW-1:0] BankMax = BankW'(N_PE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [BankW-1:0]    bank_q, bank_d;
  logic [ADDR_W:0]     row_q, row_d;
  logic [ADDR_W:0]     rows_q, rows_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N_PE-1:0]     w_en_q, w_en_d;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic                accept;
  logic                start_ok;
  logic                last_word;

  assign accept    = in_valid & in_ready;
  assign start_ok  = start & (state_q == StIdle);
  assign last_word = (bank_q == BankMax) && (row_q == rows_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    row_d    = row_q;
    rows_d   = rows_q;
    addr_d   = addr_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mode     = 1'b0;
    case (state_q)
      StIdle: begin
        mode = 1'b1;
        if (start) begin
          bank_d  = '0;
          row_d   = '0;
          rows_d  = num_rows;
          addr_d  = base_addr;
          state_d = (num_rows == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (bank_q == BankMax) begin
            bank_d = '0;
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            bank_d = bank_q + 1'b1;
          end
          if (last_word) state_d = StFlush;
        end
      end
      StFlush: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign w_en_d = accept ? (N_PE'(1) << bank_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bank_q   <= '0;
      row_q    <= '0;
      rows_q   <= '0;
      addr_q   <= '0;
      w_en_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      addr_q  <= addr_d;
      w_en_q  <= w_en_d;
      // Address/data hold between writes; only w_en marks a valid write.
      if (accept) begin
        w_addr_q <= addr_q;
        w_data_q <= in_data;
      end
    end
  end

  assign m0_w_en   = w_en_q;
  assign m0_w_addr = w_addr_q;
  assign m0_w_data = w_data_q;

`ifdef BANK_LOADER_DROPCNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (start_ok) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_bank_loader.sv
// Self-checking bench for bank_loader: table of load runs plus reset and drop-count sequences.

module tb_bank_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  num_rows;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        mode;
  logic [3:0]  m0_w_en;
  logic [7:0]  m0_w_addr;
  logic [15:0] m0_w_data;
  logic        busy;
  logic        done;
`ifdef BANK_LOADER_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  bank_loader #(
    .N_PE  (4),
    .ADDR_W(8),
    .DATA_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .num_rows (num_rows),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mode     (mode),
    .m0_w_en  (m0_w_en),
    .m0_w_addr(m0_w_addr),
    .m0_w_data(m0_w_data),
    .busy     (busy),
    .done     (done)
`ifdef BANK_LOADER_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string      name;
    logic [7:0] base;
    logic [8:0] rows;
    int         pat;
    bit         poke;
    int         lat;
  } vec_t;

  wr_t  sb[$];
  wr_t  exp_w;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic acc_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] data_of(input logic [7:0] b, input int j);
    return {b ^ 8'h5A, 8'(j)};
  endfunction

  function automatic bit valid_pat(input int pat, input int i);
    if (pat == 0) return 1'b1;
    return ((i % 4) == 0) || ((i % 4) == 3);
  endfunction

  // Every write must follow an accept by exactly one cycle and match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      acc_seen <= 1'b0;
    end else begin
      if (m0_w_en != 4'b0) begin
        if (!acc_seen) chk("write_without_accept", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(m0_w_en), 32'd0);
        end else begin
          exp_w = sb.pop_front();
          chk("w_en", 32'(m0_w_en), 32'(exp_w.en));
          chk("w_addr", 32'(m0_w_addr), 32'(exp_w.addr));
          chk("w_data", 32'(m0_w_data), 32'(exp_w.data));
        end
      end else if (acc_seen) begin
        chk("missing_write", 32'd0, 32'd1);
      end
      acc_seen <= in_valid & in_ready;
    end
  end

  task automatic push_words(input logic [7:0] base, input int total);
    wr_t w;
    for (int j = 0; j < total; j++) begin
      w.en   = 4'b0001 << (j % 4);
      w.addr = base + 8'(j / 4);
      w.data = data_of(base, j);
      sb.push_back(w);
    end
  endtask

  task automatic run_load(input string name, input logic [7:0] base, input logic [8:0] rows,
                          input int pat, input bit poke, input int exp_lat);
    int total;
    int k;
    int lat;
    int busy_n;
    int rdy_n;
    int mode_lo;
    int c;
    total   = int'(rows) * 4;
    k       = 0;
    lat     = -1;
    busy_n  = 0;
    rdy_n   = 0;
    mode_lo = 0;
    push_words(base, total);
    start     = 1'b1;
    base_addr = base;
    num_rows  = rows;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    c = 1;
    while (c <= 300 && (lat < 0 || c <= lat + 1)) begin
      if (poke && c == 5) begin
        start     = 1'b1;
        base_addr = 8'h55;
        num_rows  = 9'd7;
      end else begin
        start = 1'b0;
      end
      in_valid = (k < total) && valid_pat(pat, c - 1);
      in_data  = in_valid ? data_of(base, k) : 16'hBAD0 + 16'(c);
      @(negedge clk);
      if (lat >= 0 && c == lat + 1) begin
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_mode_idle"}, 32'(mode), 32'd1);
      end else if (done && lat < 0) begin
        lat = c;
      end
      busy_n  += int'(busy);
      rdy_n   += int'(in_ready);
      mode_lo += int'(!mode);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      c++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk({name, "_done_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_accepted"}, 32'(k), 32'(total));
    chk({name, "_busy_cycles"}, 32'(busy_n), (rows != 0) ? 32'(exp_lat - 1) : 32'd0);
    chk({name, "_ready_cycles"}, 32'(rdy_n), (rows != 0) ? 32'(exp_lat - 2) : 32'd0);
    chk({name, "_mode0_cycles"}, 32'(mode_lo), 32'(exp_lat));
    chk({name, "_writes_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_mode"}, 32'(mode), 32'd1);
    chk({name, "_w_en"}, 32'(m0_w_en), 32'd0);
    chk({name, "_w_addr"}, 32'(m0_w_addr), 32'd0);
    chk({name, "_w_data"}, 32'(m0_w_data), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   k;
    int   guard;
    vecs[0] = '{name: "base10_r2",   base: 8'h10, rows: 9'd2, pat: 0, poke: 1'b0, lat: 10};
    vecs[1] = '{name: "baseFF_wrap", base: 8'hFF, rows: 9'd2, pat: 0, poke: 1'b0, lat: 10};
    vecs[2] = '{name: "rows0",       base: 8'h33, rows: 9'd0, pat: 0, poke: 1'b0, lat: 1};
    vecs[3] = '{name: "toggle_poke", base: 8'h10, rows: 9'd2, pat: 1, poke: 1'b1, lat: 18};
    vecs[4] = '{name: "toggle_r1",   base: 8'h3C, rows: 9'd1, pat: 1, poke: 1'b0, lat: 10};
    vecs[5] = '{name: "base80_r3",   base: 8'h80, rows: 9'd3, pat: 0, poke: 1'b0, lat: 14};

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 8'h00;
    num_rows  = 9'd0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

`ifdef BANK_LOADER_DROPCNT_EN
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("drop_cnt_idle5", 32'(drop_cnt), 32'd5);
    start    = 1'b1;
    num_rows = 9'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("drop_cnt_cleared", 32'(drop_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i].name, vecs[i].base, vecs[i].rows, vecs[i].pat, vecs[i].poke, vecs[i].lat);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset after three accepted words abandons the load.
    push_words(8'h20, 8);
    start     = 1'b1;
    base_addr = 8'h20;
    num_rows  = 9'd2;
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = 0;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = data_of(8'h20, 0);
    while (k < 3 && guard < 50) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      in_data = data_of(8'h20, k);
      guard++;
    end
    chk("mid_accepted", 32'(k), 32'd3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    in_valid = 1'b0;
    chk("mid_writes_seen", 32'(sb.size()), 32'd6);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_load("rst_restart", 8'h40, 9'd1, 0, 1'b0, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
